// File: rtl/mem_arbiter_if.sv
// Handshake/bus bundle for mem_arbiter: core and debug request ports plus the shared memory port.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if;
    logic        i_coreReq;
    logic        i_coreWr;
    logic [15:0] i_coreAddr;
    logic [15:0] i_coreWData;
    logic        o_coreGrant;
    logic        o_coreDone;
    logic [15:0] o_coreRData;

    logic        i_dbgReq;
    logic        i_dbgWr;
    logic [15:0] i_dbgAddr;
    logic [15:0] i_dbgWData;
    logic        o_dbgGrant;
    logic        o_dbgDone;
    logic [15:0] o_dbgRData;

    logic [15:0] o_memAddr;
    logic [15:0] o_memDataOut;
    logic        o_memEn;
    logic        o_memWr;
    logic [15:0] i_memDataIn;
    logic        o_busy;

    modport slave (
        input  i_coreReq, i_coreWr, i_coreAddr, i_coreWData,
        output o_coreGrant, o_coreDone, o_coreRData,
        input  i_dbgReq, i_dbgWr, i_dbgAddr, i_dbgWData,
        output o_dbgGrant, o_dbgDone, o_dbgRData,
        output o_memAddr, o_memDataOut, o_memEn, o_memWr,
        input  i_memDataIn,
        output o_busy
    );

    modport master (
        output i_coreReq, i_coreWr, i_coreAddr, i_coreWData,
        input  o_coreGrant, o_coreDone, o_coreRData,
        output i_dbgReq, i_dbgWr, i_dbgAddr, i_dbgWData,
        input  o_dbgGrant, o_dbgDone, o_dbgRData,
        input  o_memAddr, o_memDataOut, o_memEn, o_memWr,
        output i_memDataIn,
        input  o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Core/debug arbiter onto one memory port with one-cycle read latency (IDLE -> ISSUE -> CAPTURE).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise debug has fixed priority.
module mem_arbiter (
    input logic          i_clk,
    input logic          i_rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic        win_dbg_q, win_dbg_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic        core_grant_q, core_grant_d;
    logic        dbg_grant_q, dbg_grant_d;
    logic        core_done_q, core_done_d;
    logic        dbg_done_q, dbg_done_d;
    logic [15:0] core_rdata_q, core_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;
    logic        core_elig, dbg_elig, pick_dbg;
`ifdef MEM_ARB_RR_EN
    logic        last_dbg_q, last_dbg_d;
`endif

    // A port is masked in its own Done cycle so a held req there is not re-served.
    assign core_elig = bus.i_coreReq & ~core_done_q;
    assign dbg_elig  = bus.i_dbgReq & ~dbg_done_q;
`ifdef MEM_ARB_RR_EN
    assign pick_dbg  = dbg_elig & (~core_elig | ~last_dbg_q);
`else
    assign pick_dbg  = dbg_elig;
`endif

    always_comb begin
        state_d      = state_q;
        win_dbg_d    = win_dbg_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_en_d     = 1'b0;
        mem_wr_d     = 1'b0;
        core_grant_d = 1'b0;
        dbg_grant_d  = 1'b0;
        core_done_d  = 1'b0;
        dbg_done_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dbg_d   = last_dbg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (core_elig | dbg_elig) begin
                    win_dbg_d    = pick_dbg;
                    wr_d         = pick_dbg ? bus.i_dbgWr    : bus.i_coreWr;
                    addr_d       = pick_dbg ? bus.i_dbgAddr  : bus.i_coreAddr;
                    wdata_d      = pick_dbg ? bus.i_dbgWData : bus.i_coreWData;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = wr_d;
                    core_grant_d = ~pick_dbg;
                    dbg_grant_d  = pick_dbg;
`ifdef MEM_ARB_RR_EN
                    last_dbg_d   = pick_dbg;
`endif
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                core_grant_d = ~win_dbg_q;
                dbg_grant_d  = win_dbg_q;
                state_d      = CAPTURE;
            end
            CAPTURE: begin
                core_done_d = ~win_dbg_q;
                dbg_done_d  = win_dbg_q;
                if (!wr_q) begin
                    if (win_dbg_q) dbg_rdata_d  = bus.i_memDataIn;
                    else           core_rdata_d = bus.i_memDataIn;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset so an in-flight write strobe drops immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            win_dbg_q    <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            core_grant_q <= 1'b0;
            dbg_grant_q  <= 1'b0;
            core_done_q  <= 1'b0;
            dbg_done_q   <= 1'b0;
            core_rdata_q <= 16'h0000;
            dbg_rdata_q  <= 16'h0000;
`ifdef MEM_ARB_RR_EN
            last_dbg_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            win_dbg_q    <= win_dbg_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            core_grant_q <= core_grant_d;
            dbg_grant_q  <= dbg_grant_d;
            core_done_q  <= core_done_d;
            dbg_done_q   <= dbg_done_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_dbg_q   <= last_dbg_d;
`endif
        end
    end

    assign bus.o_memAddr    = addr_q;
    assign bus.o_memDataOut = wdata_q;
    assign bus.o_memEn      = mem_en_q;
    assign bus.o_memWr      = mem_wr_q;
    assign bus.o_coreGrant  = core_grant_q;
    assign bus.o_dbgGrant   = dbg_grant_q;
    assign bus.o_coreDone   = core_done_q;
    assign bus.o_dbgDone    = dbg_done_q;
    assign bus.o_coreRData  = core_rdata_q;
    assign bus.o_dbgRData   = dbg_rdata_q;
    assign bus.o_busy       = (state_q != IDLE);
endmodule
